// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the FIFO controller slice.
package fifo_pkg;

  localparam int unsigned DEFAULT_DEPTH = 8;
  localparam int unsigned DEFAULT_WIDTH = 8;

  // Arbitration priority encodings: which side wins when both are legal.
  localparam logic PRIO_PUSH = 1'b0;
  localparam logic PRIO_POP  = 1'b1;

  // Ceiling log2, usable in constant expressions (port widths, localparams).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_row_dec.sv
// Pointer-to-row decoder: turns the granted pointer into a one-hot row select.
module fifo_row_dec
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic [clog2(DEPTH)-1:0] ptr,
  input  logic                    en,
  output logic [DEPTH-1:0]        onehot
);

  localparam int unsigned ADDR_W = clog2(DEPTH);

  // One bit per row; all zero when no access is granted.
  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (en && (ptr == ADDR_W'(i))) begin
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_ctrl.sv
// Sequencing controller for a single-ported latch FIFO array: arbitrates
// push/pop, owns pointers and occupancy, and drives the array from registers.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push_req,
  input  logic [WIDTH-1:0]        push_data,
  output logic                    push_gnt,
  input  logic                    pop_req,
  output logic                    pop_gnt,
  output logic [WIDTH-1:0]        pop_data,
  output logic                    pop_dval,
  output logic                    full,
  output logic                    empty,
  output logic [clog2(DEPTH):0]   count,
  output logic [DEPTH-1:0]        row_sel,
  output logic                    write_en,
  output logic [WIDTH-1:0]        arr_wdata,
  input  logic [WIDTH-1:0]        arr_rdata
);

  localparam int unsigned       ADDR_W   = clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] sel_ptr;
  logic [ADDR_W:0]   count_nxt;
  logic [DEPTH-1:0]  dec_onehot;
  logic              prio;
  logic              push_ok;
  logic              pop_ok;
  logic              both_ok;
  logic              rd_pend;

  // Arbitration: one grant per cycle, round-robin only when both sides legal.
  always_comb begin
    push_ok  = push_req && !full;
    pop_ok   = pop_req && !empty;
    both_ok  = push_ok && pop_ok;
    push_gnt = 1'b0;
    pop_gnt  = 1'b0;
    if (both_ok) begin
      push_gnt = (prio == PRIO_PUSH);
      pop_gnt  = (prio == PRIO_POP);
    end else begin
      push_gnt = push_ok;
      pop_gnt  = pop_ok;
    end
  end

  // Granted pointer selection and next occupancy.
  always_comb begin
    sel_ptr   = push_gnt ? wr_ptr : rd_ptr;
    count_nxt = count;
    if (push_gnt) begin
      count_nxt = count + 1'b1;
    end else if (pop_gnt) begin
      count_nxt = count - 1'b1;
    end
  end

  fifo_row_dec #(
    .DEPTH (DEPTH)
  ) u_row_dec (
    .ptr    (sel_ptr),
    .en     (push_gnt | pop_gnt),
    .onehot (dec_onehot)
  );

  // Pointers, occupancy, flags and round-robin priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
      prio   <= PRIO_PUSH;
    end else begin
      if (push_gnt) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (pop_gnt) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == FULL_CNT);
      if (both_ok) begin
        prio <= push_gnt ? PRIO_POP : PRIO_PUSH;
      end
    end
  end

  // Registered array drive so latch enables only change on a clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_sel   <= '0;
      write_en  <= 1'b0;
      arr_wdata <= '0;
    end else begin
      row_sel  <= dec_onehot;
      write_en <= push_gnt;
      if (push_gnt) begin
        arr_wdata <= push_data;
      end
    end
  end

  // Read return: capture the bus in the access cycle, flag it the cycle after.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_pend  <= 1'b0;
      pop_data <= '0;
      pop_dval <= 1'b0;
    end else begin
      rd_pend  <= pop_gnt;
      pop_dval <= rd_pend;
      if (rd_pend) begin
        pop_data <= arr_rdata;
      end
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed self-checking bench for fifo_ctrl with a behavioural latch array.
module tb_fifo_ctrl;

  logic       clk;
  logic       rst_n;
  logic       push_req;
  logic [7:0] push_data;
  logic       push_gnt;
  logic       pop_req;
  logic       pop_gnt;
  logic [7:0] pop_data;
  logic       pop_dval;
  logic       full;
  logic       empty;
  logic [3:0] count;
  logic [7:0] row_sel;
  logic       write_en;
  logic [7:0] arr_wdata;
  logic [7:0] arr_rdata;

  logic [7:0] mem [8];
  logic       g_push;
  logic       g_pop;
  int         checks;
  int         errors;

  fifo_ctrl #(
    .DEPTH (8),
    .WIDTH (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_req  (push_req),
    .push_data (push_data),
    .push_gnt  (push_gnt),
    .pop_req   (pop_req),
    .pop_gnt   (pop_gnt),
    .pop_data  (pop_data),
    .pop_dval  (pop_dval),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .row_sel   (row_sel),
    .write_en  (write_en),
    .arr_wdata (arr_wdata),
    .arr_rdata (arr_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Array model: row written while selected with write_en, read otherwise.
  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (write_en && row_sel[i]) mem[i] <= arr_wdata;
    end
  end

  always_comb begin
    arr_rdata = '0;
    for (int j = 0; j < 8; j++) begin
      if (row_sel[j] && !write_en) arr_rdata = mem[j];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive requests, sample grants mid-cycle, then step past the edge.
  task automatic cyc(input logic pr, input logic [7:0] pd, input logic qr);
    push_req  = pr;
    push_data = pd;
    pop_req   = qr;
    #2;
    g_push = push_gnt;
    g_pop  = pop_gnt;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] oh(input int r);
    logic [7:0] one;
    one = 8'd1;
    return one << r;
  endfunction

  initial begin
    logic [7:0] c_rows  [6];
    logic [3:0] c_cnt   [6];
    logic       c_push  [6];
    logic [7:0] d_exp   [4];
    checks = 0;
    errors = 0;
    for (int m = 0; m < 8; m++) mem[m] = '0;
    rst_n = 1'b0;
    push_req = 1'b0;
    push_data = '0;
    pop_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset values
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_row_sel", row_sel, 0);
    chk("rst_write_en", write_en, 0);
    chk("rst_arr_wdata", arr_wdata, 0);
    chk("rst_pop_data", pop_data, 0);
    chk("rst_pop_dval", pop_dval, 0);
    rst_n = 1'b1;

    // Three back-to-back pushes
    cyc(1, 8'h11, 0);
    chk("p1_gnt", g_push, 1);
    chk("p1_row", row_sel, 8'h01);
    chk("p1_we", write_en, 1);
    chk("p1_wdata", arr_wdata, 8'h11);
    chk("p1_empty", empty, 0);
    cyc(1, 8'h22, 0);
    chk("p2_row", row_sel, 8'h02);
    chk("p2_wdata", arr_wdata, 8'h22);
    cyc(1, 8'h33, 0);
    chk("p3_row", row_sel, 8'h04);
    chk("p3_we", write_en, 1);
    chk("p3_count", count, 3);

    // Fill to DEPTH
    cyc(1, 8'h44, 0);
    cyc(1, 8'h55, 0);
    cyc(1, 8'h66, 0);
    cyc(1, 8'h77, 0);
    chk("p7_full", full, 0);
    cyc(1, 8'h88, 0);
    chk("p8_row", row_sel, 8'h80);
    chk("p8_count", count, 8);
    chk("p8_full", full, 1);

    // Ninth push held off while full
    cyc(1, 8'h99, 0);
    chk("p9_gnt", g_push, 0);
    chk("p9_row", row_sel, 8'h00);
    chk("p9_we", write_en, 0);
    chk("p9_count", count, 8);

    // Full with both requests: pop only
    cyc(1, 8'h99, 1);
    chk("fpop_push_gnt", g_push, 0);
    chk("fpop_pop_gnt", g_pop, 1);
    chk("fpop_row", row_sel, 8'h01);
    chk("fpop_we", write_en, 0);
    chk("fpop_count", count, 7);
    chk("fpop_full", full, 0);

    // Held push now lands in row 0 (wr_ptr wrapped, unchanged by the stall)
    cyc(1, 8'h99, 0);
    chk("p9b_gnt", g_push, 1);
    chk("p9b_dval", pop_dval, 1);
    chk("p9b_data", pop_data, 8'h11);
    chk("p9b_row", row_sel, 8'h01);
    chk("p9b_we", write_en, 1);
    chk("p9b_full", full, 1);

    // Pop four back to count 4
    cyc(0, 8'h00, 1);
    chk("d1_dval", pop_dval, 0);
    chk("d1_row", row_sel, 8'h02);
    cyc(0, 8'h00, 1);
    chk("d2_dval", pop_dval, 1);
    chk("d2_data", pop_data, 8'h22);
    cyc(0, 8'h00, 1);
    chk("d3_data", pop_data, 8'h33);
    cyc(0, 8'h00, 1);
    chk("d4_data", pop_data, 8'h44);
    chk("d4_count", count, 4);
    cyc(0, 8'h00, 0);
    chk("d5_dval", pop_dval, 1);
    chk("d5_data", pop_data, 8'h55);
    chk("d5_row", row_sel, 8'h00);
    cyc(0, 8'h00, 0);
    chk("d6_dval", pop_dval, 0);

    // Continuous contention from count 4: push, pop, push, ...
    c_push = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    c_rows = '{8'h02, 8'h20, 8'h04, 8'h40, 8'h08, 8'h80};
    c_cnt  = '{4'd5, 4'd4, 4'd5, 4'd4, 4'd5, 4'd4};
    for (int k = 0; k < 6; k++) begin
      cyc(1, 8'hA1 + 8'(k), 1);
      chk($sformatf("ct%0d_push", k), g_push, c_push[k]);
      chk($sformatf("ct%0d_pop", k), g_pop, !c_push[k]);
      chk($sformatf("ct%0d_row", k), row_sel, c_rows[k]);
      chk($sformatf("ct%0d_count", k), count, c_cnt[k]);
      chk($sformatf("ct%0d_dval", k), pop_dval, (k == 2 || k == 4));
      if (k == 2) chk("ct2_data", pop_data, 8'h66);
      if (k == 4) chk("ct4_data", pop_data, 8'h77);
    end
    cyc(0, 8'h00, 0);
    chk("ct_tail_dval", pop_dval, 1);
    chk("ct_tail_data", pop_data, 8'h88);

    // Drain remaining four, order preserved across wrap
    d_exp = '{8'h99, 8'hA1, 8'hA3, 8'hA5};
    for (int k = 0; k < 6; k++) begin
      cyc(0, 8'h00, (k < 4));
      if (k >= 1 && k <= 4) begin
        chk($sformatf("dr%0d_dval", k), pop_dval, 1);
        chk($sformatf("dr%0d_data", k), pop_data, d_exp[k-1]);
      end else begin
        chk($sformatf("dr%0d_dval", k), pop_dval, 0);
      end
    end
    chk("dr_empty", empty, 1);
    chk("dr_count", count, 0);

    // Empty with both requests: push, push, pop
    cyc(1, 8'hB1, 1);
    chk("e1_push", g_push, 1);
    chk("e1_pop", g_pop, 0);
    chk("e1_row", row_sel, 8'h10);
    cyc(1, 8'hB2, 1);
    chk("e2_push", g_push, 1);
    chk("e2_pop", g_pop, 0);
    chk("e2_count", count, 2);
    cyc(1, 8'hB3, 1);
    chk("e3_push", g_push, 0);
    chk("e3_pop", g_pop, 1);
    chk("e3_row", row_sel, 8'h10);
    chk("e3_count", count, 1);
    cyc(0, 8'h00, 1);
    chk("e4_data", pop_data, 8'hB1);
    chk("e4_dval", pop_dval, 1);
    cyc(0, 8'h00, 0);
    chk("e5_data", pop_data, 8'hB2);
    chk("e5_empty", empty, 1);

    // Wrap: 20 push/pop pairs starting at row 6
    for (int k = 0; k < 20; k++) begin
      cyc(1, 8'hC0 + 8'(k), 0);
      chk($sformatf("w%0d_prow", k), row_sel, oh((6 + k) % 8));
      chk($sformatf("w%0d_pcnt", k), count, 1);
      if (k >= 1) begin
        chk($sformatf("w%0d_dval", k), pop_dval, 1);
        chk($sformatf("w%0d_data", k), pop_data, 8'hC0 + 8'(k - 1));
      end
      cyc(0, 8'h00, 1);
      chk($sformatf("w%0d_rrow", k), row_sel, oh((6 + k) % 8));
      chk($sformatf("w%0d_rcnt", k), count, 0);
    end
    cyc(0, 8'h00, 0);
    chk("w_tail_data", pop_data, 8'hD3);
    chk("w_tail_dval", pop_dval, 1);

    // Reset in the cycle after a pop grant
    cyc(1, 8'hE5, 0);
    chk("r_push_count", count, 1);
    cyc(0, 8'h00, 1);
    chk("r_pop_gnt", g_pop, 1);
    rst_n = 1'b0;
    cyc(0, 8'h00, 0);
    chk("r1_dval", pop_dval, 0);
    chk("r1_data", pop_data, 0);
    chk("r1_row", row_sel, 0);
    chk("r1_we", write_en, 0);
    chk("r1_wdata", arr_wdata, 0);
    chk("r1_count", count, 0);
    chk("r1_empty", empty, 1);
    chk("r1_full", full, 0);
    cyc(0, 8'h00, 0);
    chk("r2_dval", pop_dval, 0);
    rst_n = 1'b1;
    cyc(0, 8'h00, 1);
    chk("r3_pop_gnt", g_pop, 0);
    chk("r3_dval", pop_dval, 0);
    cyc(1, 8'hF0, 0);
    chk("r4_row", row_sel, 8'h01);
    chk("r4_wdata", arr_wdata, 8'hF0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
